// File: rtl/beezip_job_arbiter_if.sv
// Bus bundle between the job arbiter, its requester channels and the beezip pipeline.
// slave is the arbiter's view; master is the view of whatever drives it.
interface beezip_job_arbiter_if #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned ISSUE_BYTES = 32,
   parameter int unsigned ADDR_W      = 32
);
   localparam int unsigned ChW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH-1:0]               s_valid;
   logic [NUM_CH-1:0]               s_ready;
   logic [NUM_CH*ISSUE_BYTES*8-1:0] s_data;
   logic [NUM_CH-1:0]               s_delim;
   logic                            m_valid;
   logic                            m_ready;
   logic [ISSUE_BYTES*8-1:0]        m_data;
   logic                            m_delim;
   logic [ADDR_W-1:0]               m_head_addr;
   logic                            seq_valid;
   logic                            seq_ready;
   logic                            seq_last;
   logic [NUM_CH-1:0]               seq_ch_valid;
   logic [NUM_CH-1:0]               seq_ch_ready;
   logic [ChW-1:0]                  seq_owner;
   logic                            busy;

   modport slave (
      input  s_valid, s_data, s_delim, m_ready, seq_valid, seq_last, seq_ch_ready,
      output s_ready, m_valid, m_data, m_delim, m_head_addr, seq_ready, seq_ch_valid,
             seq_owner, busy
   );

   modport master (
      output s_valid, s_data, s_delim, m_ready, seq_valid, seq_last, seq_ch_ready,
      input  s_ready, m_valid, m_data, m_delim, m_head_addr, seq_ready, seq_ch_valid,
             seq_owner, busy
   );
endinterface

// File: rtl/beezip_job_arbiter.sv
// Round-robin job arbiter in front of beezip: grants one channel per job, tracks job owners
// in an in-order FIFO and steers returning sequence packets back to the owning channel.
module beezip_job_arbiter #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned ISSUE_BYTES = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned OWNER_DEPTH = 8
) (
   input logic                  clk,
   input logic                  rst,
   beezip_job_arbiter_if.slave  bus
);
   localparam int unsigned DataW = ISSUE_BYTES * 8;
   localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PtrW  = (OWNER_DEPTH > 1) ? $clog2(OWNER_DEPTH) : 1;
   localparam int unsigned CntW  = PtrW + 1;

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e          state_q;
   logic [ChW-1:0]  g_q;
   logic [ChW-1:0]  last_grant_q;
   logic [ADDR_W-1:0] head_addr_q;
   logic [ChW-1:0]  owner_q [OWNER_DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;

   logic           found;
   logic [ChW-1:0] pick;
   logic [ChW-1:0] cand;
   logic           grant_ok;
   logic           push;
   logic           pop;
   logic           beat;
   logic           fifo_empty;
   logic [ChW-1:0] head;

   // Round-robin search starting just after the last channel that finished a job.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
         cand = ChW'((32'(last_grant_q) + k) % NUM_CH);
         if (!found && bus.s_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign fifo_empty = (count_q == '0);
   assign head       = owner_q[rd_ptr_q];
   // Full check deliberately ignores a same-cycle pop.
   assign grant_ok   = (state_q == StIdle) && found && (count_q < CntW'(OWNER_DEPTH));
   assign push       = grant_ok;

   always_comb begin
      bus.m_valid = 1'b0;
      bus.m_data  = '0;
      bus.m_delim = 1'b0;
      bus.s_ready = '0;
      if (state_q == StGrant) begin
         bus.m_valid        = bus.s_valid[g_q];
         bus.m_data         = bus.s_data[32'(g_q) * DataW +: DataW];
         bus.m_delim        = bus.s_delim[g_q];
         bus.s_ready[g_q]   = bus.m_ready;
      end
   end

   assign beat            = bus.m_valid && bus.m_ready;
   assign bus.m_head_addr = head_addr_q;

   always_comb begin
      bus.seq_ch_valid = '0;
      bus.seq_ready    = 1'b0;
      bus.seq_owner    = '0;
      if (!fifo_empty) begin
         bus.seq_owner          = head;
         bus.seq_ch_valid[head] = bus.seq_valid;
         bus.seq_ready          = bus.seq_ch_ready[head];
      end
   end

   assign pop      = bus.seq_valid && bus.seq_ready && bus.seq_last;
   assign bus.busy = (state_q == StGrant) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         g_q          <= '0;
         last_grant_q <= ChW'(NUM_CH - 1);
         head_addr_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant_ok) begin
                  g_q     <= pick;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               if (beat) begin
                  head_addr_q <= head_addr_q + ADDR_W'(ISSUE_BYTES);
                  if (bus.m_delim) begin
                     last_grant_q <= g_q;
                     state_q      <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
         if (push) begin
            owner_q[wr_ptr_q] <= pick;
            wr_ptr_q          <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) !(pop && fifo_empty))
      else $error("owner FIFO popped while empty");
   assert property (@(posedge clk) disable iff (rst) !(push && !pop &&
                                                        count_q == CntW'(OWNER_DEPTH)))
      else $error("owner FIFO pushed while full");
endmodule

// File: tb/tb_beezip_job_arbiter.sv
// Randomized bench for beezip_job_arbiter against a job-level reference model (current owner,
// round-robin pointer, address counter and an owner queue).
module tb_beezip_job_arbiter;
   localparam int NUM_CH      = 4;
   localparam int ISSUE_BYTES = 32;
   localparam int ADDR_W      = 32;
   localparam int OWNER_DEPTH = 8;
   localparam int DW          = ISSUE_BYTES * 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   beezip_job_arbiter_if #(.NUM_CH(NUM_CH), .ISSUE_BYTES(ISSUE_BYTES), .ADDR_W(ADDR_W)) bif ();

   beezip_job_arbiter #(
      .NUM_CH(NUM_CH), .ISSUE_BYTES(ISSUE_BYTES), .ADDR_W(ADDR_W), .OWNER_DEPTH(OWNER_DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bif)
   );

   int checks   = 0;
   int failures = 0;

   // Reference state: owner of the job being forwarded (-1 = none), last finished owner,
   // head address, and the queue of jobs awaiting their return packets.
   int          mdl_owner;
   int          mdl_last;
   logic [31:0] mdl_addr;
   int          mdl_q[$];
   bit          chk_en = 1'b0;

   task automatic check_eq(input string tag, input logic [DW-1:0] act,
                           input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic check_outputs();
      logic              e_mv, e_md, e_sr, e_busy;
      logic [DW-1:0]     e_md_data;
      logic [NUM_CH-1:0] e_srdy, e_scv;
      logic [1:0]        e_own;
      e_mv = 0; e_md = 0; e_md_data = '0; e_srdy = '0;
      e_scv = '0; e_sr = 0; e_own = '0;
      if (mdl_owner >= 0) begin
         e_mv              = bif.s_valid[mdl_owner];
         e_md              = bif.s_delim[mdl_owner];
         e_md_data         = bif.s_data[mdl_owner*DW +: DW];
         e_srdy[mdl_owner] = bif.m_ready;
      end
      if (mdl_q.size() > 0) begin
         e_own           = 2'(mdl_q[0]);
         e_scv[mdl_q[0]] = bif.seq_valid;
         e_sr            = bif.seq_ch_ready[mdl_q[0]];
      end
      e_busy = (mdl_owner >= 0) || (mdl_q.size() > 0);
      check_eq("m_valid", DW'(bif.m_valid), DW'(e_mv));
      check_eq("m_delim", DW'(bif.m_delim), DW'(e_md));
      check_eq("m_data", bif.m_data, e_md_data);
      check_eq("s_ready", DW'(bif.s_ready), DW'(e_srdy));
      check_eq("m_head_addr", DW'(bif.m_head_addr), DW'(mdl_addr));
      check_eq("seq_ch_valid", DW'(bif.seq_ch_valid), DW'(e_scv));
      check_eq("seq_ready", DW'(bif.seq_ready), DW'(e_sr));
      check_eq("seq_owner", DW'(bif.seq_owner), DW'(e_own));
      check_eq("busy", DW'(bif.busy), DW'(e_busy));
   endtask

   task automatic model_update();
      int  size_before;
      bit  pop;
      if (rst) begin
         mdl_owner = -1;
         mdl_last  = NUM_CH - 1;
         mdl_addr  = '0;
         mdl_q.delete();
         return;
      end
      size_before = mdl_q.size();
      pop = (size_before > 0) && bif.seq_valid && bif.seq_ch_ready[mdl_q[0]] && bif.seq_last;
      if (mdl_owner < 0) begin
         if (size_before < OWNER_DEPTH) begin
            for (int k = 1; k <= NUM_CH; k++) begin
               int c;
               c = (mdl_last + k) % NUM_CH;
               if (mdl_owner < 0 && bif.s_valid[c]) begin
                  mdl_owner = c;
                  mdl_q.push_back(c);
               end
            end
         end
      end else if (bif.s_valid[mdl_owner] && bif.m_ready) begin
         mdl_addr = mdl_addr + 32'(ISSUE_BYTES);
         if (bif.s_delim[mdl_owner]) begin
            mdl_last  = mdl_owner;
            mdl_owner = -1;
         end
      end
      if (pop) void'(mdl_q.pop_front());
   endtask

   task automatic tick();
      #1;
      if (chk_en) check_outputs();
      model_update();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bif.s_valid = '0; bif.s_delim = '0; bif.s_data = '0; bif.m_ready = 1'b0;
      bif.seq_valid = 1'b0; bif.seq_last = 1'b0; bif.seq_ch_ready = '0;
   endtask

   task automatic rand_data();
      for (int w = 0; w < NUM_CH * DW / 32; w++) bif.s_data[w*32 +: 32] = $urandom;
   endtask

   initial begin
      int sv_pct, seq_pct, rdy_pct;
      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      tick();
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // Saturate the owner queue with one-beat jobs while the return path stays silent.
      bif.s_valid = '1; bif.s_delim = '1; bif.m_ready = 1'b1;
      repeat (25) begin rand_data(); tick(); end
      bif.seq_valid = 1'b1; bif.seq_last = 1'b1; bif.seq_ch_ready = '1;
      tick();
      bif.seq_valid = 1'b0;
      repeat (6) begin rand_data(); tick(); end
      bif.seq_valid = 1'b1;
      repeat (12) tick();
      drive_idle();
      repeat (2) tick();

      sv_pct = 70; seq_pct = 30; rdy_pct = 70;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc % 150 == 0) begin
            sv_pct  = $urandom_range(20, 95);
            seq_pct = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 95);
            rdy_pct = $urandom_range(20, 100);
         end
         for (int c = 0; c < NUM_CH; c++) begin
            bif.s_valid[c]      = ($urandom_range(0, 99) < sv_pct);
            bif.s_delim[c]      = ($urandom_range(0, 99) < 30);
            bif.seq_ch_ready[c] = ($urandom_range(0, 99) < 70);
         end
         rand_data();
         bif.m_ready   = ($urandom_range(0, 99) < rdy_pct);
         bif.seq_valid = ($urandom_range(0, 99) < seq_pct);
         bif.seq_last  = ($urandom_range(0, 99) < 40);
         rst           = ($urandom_range(0, 399) == 0);
         tick();
      end
      rst = 1'b0;
      drive_idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
